// File: rtl/addr_reg_burst.sv
// addr_reg_burst: memory address register with load/increment paths and an
// autonomous burst engine that steps the address once per accepted beat.
module addr_reg_burst #(
   parameter int ADDR_W    = 12,
   parameter int BURST_MAX = 8,
   parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_en,
   input  logic              write_en,
   input  logic              inc_en,
   input  logic [ADDR_W-1:0] pc_datain,
   input  logic [ADDR_W-1:0] bus_datain,
   input  logic              burst_start,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              burst_abort,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] dataout,
   output logic              mem_req,
   output logic              busy,
   output logic              burst_done,
   output logic [LEN_W-1:0]  beat_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [LEN_W-1:0] remaining;
   logic [LEN_W-1:0] eff_len;

   // Requested length clamped to the largest burst the engine supports.
   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
      if (len > LEN_W'(BURST_MAX))
         return LEN_W'(BURST_MAX);
      else
         return len;
   endfunction

   // Address increment; the all-ones address wraps back to zero.
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(1);
   endfunction

   assign eff_len = sat_len(burst_len);

   // Outputs decode the state register only, so no input reaches an output combinationally.
   assign mem_req    = (state == S_BUSY);
   assign busy       = (state == S_BUSY);
   assign burst_done = (state == S_DONE);

   // Address register: beats advance it while busy, otherwise the load/increment paths apply.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout <= '0;
      end else if (state == S_BUSY) begin
         if (mem_ready)
            dataout <= addr_inc(dataout);
      end else if (pc_en) begin
         dataout <= pc_datain;
      end else if (write_en) begin
         dataout <= bus_datain;
      end else if (inc_en) begin
         dataout <= addr_inc(dataout);
      end
   end

   // Burst control: state, remaining beats and accepted-beat count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         remaining <= '0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // A zero-length request is dropped without disturbing the last count.
               if (burst_start && (eff_len != '0)) begin
                  state     <= S_BUSY;
                  remaining <= eff_len;
                  beat_cnt  <= '0;
               end
            end
            S_BUSY: begin
               if (mem_ready) begin
                  beat_cnt  <= beat_cnt + LEN_W'(1);
                  remaining <= remaining - LEN_W'(1);
               end
               // Abort wins over completion: an aborted burst never pulses done.
               if (burst_abort)
                  state <= S_IDLE;
               else if (mem_ready && (remaining == LEN_W'(1)))
                  state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addr_reg_burst.sv
// tb_addr_reg_burst: directed vectors with hand-computed expectations for addr_reg_burst.
module tb_addr_reg_burst;

   localparam int ADDR_W    = 12;
   localparam int BURST_MAX = 8;
   localparam int LEN_W     = $clog2(BURST_MAX + 1);

   logic              clk = 1'b0;
   logic              reset;
   logic              pc_en, write_en, inc_en;
   logic [ADDR_W-1:0] pc_datain, bus_datain;
   logic              burst_start, burst_abort, mem_ready;
   logic [LEN_W-1:0]  burst_len;
   logic [ADDR_W-1:0] dataout;
   logic              mem_req, busy, burst_done;
   logic [LEN_W-1:0]  beat_cnt;

   int n_chk = 0;
   int n_err = 0;

   addr_reg_burst #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .pc_en(pc_en), .write_en(write_en), .inc_en(inc_en),
      .pc_datain(pc_datain), .bus_datain(bus_datain),
      .burst_start(burst_start), .burst_len(burst_len),
      .burst_abort(burst_abort), .mem_ready(mem_ready),
      .dataout(dataout), .mem_req(mem_req), .busy(busy),
      .burst_done(burst_done), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_en = 0; write_en = 0; inc_en = 0;
      burst_start = 0; burst_abort = 0; mem_ready = 0;
      burst_len = '0;
   endtask

   logic [ADDR_W-1:0] exp_hs [7];
   logic [6:0]        rdy_pat;

   initial begin
      exp_hs = '{12'h100, 12'h101, 12'h101, 12'h101, 12'h102, 12'h103, 12'h103};
      rdy_pat = 7'b1011001;   // bit i drives mem_ready in busy cycle i: 1,0,0,1,1,0,1

      reset = 0;
      idle_inputs();
      pc_datain = '0; bus_datain = '0;
      tick(); tick();
      check("rst_dataout", 32'(dataout), 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(burst_done), 32'h0);
      check("rst_beat_cnt", 32'(beat_cnt), 32'h0);
      reset = 1;
      tick();

      // Priority: pc over bus, then bus, then increment
      pc_en = 1; write_en = 1; pc_datain = 12'h0A5; bus_datain = 12'h3C0;
      tick();
      check("prio_pc", 32'(dataout), 32'h0A5);
      pc_en = 0;
      tick();
      check("prio_bus", 32'(dataout), 32'h3C0);
      write_en = 0; inc_en = 1;
      tick();
      check("prio_inc", 32'(dataout), 32'h3C1);
      inc_en = 0;

      // Increment wrap
      write_en = 1; bus_datain = 12'hFFF;
      tick();
      write_en = 0; inc_en = 1;
      tick();
      check("inc_wrap", 32'(dataout), 32'h000);
      inc_en = 0;

      // Burst wrapping through the top of the address space
      write_en = 1; bus_datain = 12'hFFE;
      tick();
      write_en = 0; burst_start = 1; burst_len = 3; mem_ready = 1;
      tick();
      burst_start = 0;
      check("wb_req", 32'(mem_req), 32'h1);
      check("wb_a0", 32'(dataout), 32'hFFE);
      tick();
      check("wb_a1", 32'(dataout), 32'hFFF);
      tick();
      check("wb_a2", 32'(dataout), 32'h000);
      tick();
      check("wb_final", 32'(dataout), 32'h001);
      check("wb_done", 32'(burst_done), 32'h1);
      check("wb_req_off", 32'(mem_req), 32'h0);
      check("wb_cnt", 32'(beat_cnt), 32'h3);
      mem_ready = 0;
      tick();
      check("wb_done_pulse", 32'(burst_done), 32'h0);
      check("wb_idle", 32'(busy), 32'h0);

      // Handshake stalls
      write_en = 1; bus_datain = 12'h100;
      tick();
      write_en = 0; burst_start = 1; burst_len = 4;
      tick();
      burst_start = 0;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy_pat[i];
         check($sformatf("hs_req%0d", i), 32'(mem_req), 32'h1);
         check($sformatf("hs_addr%0d", i), 32'(dataout), 32'(exp_hs[i]));
         check($sformatf("hs_nodone%0d", i), 32'(burst_done), 32'h0);
         tick();
      end
      mem_ready = 0;
      check("hs_final", 32'(dataout), 32'h104);
      check("hs_done", 32'(burst_done), 32'h1);
      check("hs_cnt", 32'(beat_cnt), 32'h4);
      tick();

      // Blocked inputs while busy, and length clamp
      write_en = 1; bus_datain = 12'h000;
      tick();
      write_en = 0; burst_start = 1; burst_len = 15;
      tick();
      check("blk_busy", 32'(busy), 32'h1);
      pc_en = 1; pc_datain = 12'h555; write_en = 1; bus_datain = 12'h666;
      inc_en = 1; burst_start = 1; burst_len = 1;
      tick();
      idle_inputs();
      check("blk_addr", 32'(dataout), 32'h000);
      check("blk_still_busy", 32'(busy), 32'h1);
      mem_ready = 1;
      for (int i = 0; i < 7; i++) tick();
      check("clamp_busy7", 32'(busy), 32'h1);
      check("clamp_addr7", 32'(dataout), 32'h007);
      tick();
      mem_ready = 0;
      check("clamp_done", 32'(burst_done), 32'h1);
      check("clamp_cnt", 32'(beat_cnt), 32'h8);
      check("clamp_addr", 32'(dataout), 32'h008);
      tick();
      burst_start = 1; burst_len = 0;
      tick();
      burst_start = 0;
      check("zero_len_busy", 32'(busy), 32'h0);
      check("zero_len_cnt", 32'(beat_cnt), 32'h8);
      tick();
      check("zero_len_busy2", 32'(busy), 32'h0);

      // Abort on the second accepted beat
      write_en = 1; bus_datain = 12'h040;
      tick();
      write_en = 0; burst_start = 1; burst_len = 5;
      tick();
      burst_start = 0; mem_ready = 1;
      tick();
      check("ab_a1", 32'(dataout), 32'h041);
      burst_abort = 1;
      tick();
      burst_abort = 0; mem_ready = 0;
      check("ab_addr", 32'(dataout), 32'h042);
      check("ab_cnt", 32'(beat_cnt), 32'h2);
      check("ab_idle", 32'(busy), 32'h0);
      check("ab_nodone", 32'(burst_done), 32'h0);
      tick();
      check("ab_nodone2", 32'(burst_done), 32'h0);

      // Asynchronous reset mid-burst
      burst_start = 1; burst_len = 5;
      tick();
      burst_start = 0;
      check("ar_req_before", 32'(mem_req), 32'h1);
      #2 reset = 0;
      #1;
      check("ar_req", 32'(mem_req), 32'h0);
      check("ar_addr", 32'(dataout), 32'h000);
      check("ar_cnt", 32'(beat_cnt), 32'h0);
      check("ar_busy", 32'(busy), 32'h0);
      reset = 1;
      tick();
      check("ar_nodone", 32'(burst_done), 32'h0);

      // Load in the same cycle as burst_start
      burst_start = 1; write_en = 1; bus_datain = 12'h200; burst_len = 2; mem_ready = 1;
      tick();
      burst_start = 0; write_en = 0;
      check("ls_a0", 32'(dataout), 32'h200);
      tick();
      check("ls_a1", 32'(dataout), 32'h201);
      tick();
      mem_ready = 0;
      check("ls_final", 32'(dataout), 32'h202);
      check("ls_done", 32'(burst_done), 32'h1);
      check("ls_cnt", 32'(beat_cnt), 32'h2);
      inc_en = 1;
      tick();
      inc_en = 0;
      check("done_inc", 32'(dataout), 32'h203);
      check("done_to_idle", 32'(burst_done), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
